// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the LCD bus sequencer
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT
    } lcd_state_e;

    localparam int LCD_ON_BIT   = 31;
    localparam int LCD_GO_BIT   = 30;
    localparam int LCD_RS_BIT   = 9;
    localparam int LCD_RW_BIT   = 8;
    localparam int LCD_DATA_LSB = 0;

    localparam logic [7:0] LCD_OP_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_OP_HOME     = 8'h02;
    localparam logic [7:0] LCD_OP_HOME_ALT = 8'h03;

    // Clear and return-home need the long execution wait on the panel controller.
    function automatic logic lcd_is_long_cmd(input logic rs, input logic rw, input logic [7:0] data);
        return !rs && !rw &&
               (data == LCD_OP_CLEAR || data == LCD_OP_HOME || data == LCD_OP_HOME_ALT);
    endfunction

    function automatic int lcd_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_bus_sequencer.sv
// rtl/lcd_bus_sequencer.sv - drives HD44780-style bus cycles from the LSU LCD register word
module lcd_bus_sequencer
    import lcd_pkg::*;
#(
    parameter int T_SETUP = 4,
    parameter int T_PW    = 24,
    parameter int T_HOLD  = 4,
    parameter int T_EXEC  = 2000,
    parameter int T_CLR   = 76000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] lcd_word_i,
    output logic        lcd_on_o,
    output logic        lcd_en_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic [7:0]  lcd_data_o,
    output logic        lcd_data_oe_o,
    output logic        busy_o,
    output logic        overrun_o
);

    localparam int T_MAX = lcd_max(lcd_max(lcd_max(T_SETUP, T_PW), lcd_max(T_HOLD, T_EXEC)), T_CLR);
    localparam int CW    = $clog2(T_MAX + 1);

    if (T_SETUP < 1 || T_PW < 1 || T_HOLD < 1 || T_EXEC < 1 || T_CLR < 1) begin : g_bad_timing
        $error("lcd_bus_sequencer: every timing parameter must be at least 1");
    end

    lcd_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            go_ref_q;
    logic            on_q;
    logic            act_rs_q, act_rw_q;
    logic [7:0]      act_data_q;
    logic            pend_q;
    logic            pend_rs_q, pend_rw_q;
    logic [7:0]      pend_data_q;
    logic            overrun_q;

    logic            launch;
    logic            accept;
    logic            cnt_zero;
    logic            wait_done;
    logic            word_rs, word_rw;
    logic [7:0]      word_data;
    logic            unused_word_bits;

    assign word_rs          = lcd_word_i[LCD_RS_BIT];
    assign word_rw          = lcd_word_i[LCD_RW_BIT];
    assign word_data        = lcd_word_i[LCD_DATA_LSB +: 8];
    assign unused_word_bits = ^lcd_word_i[29:10];

    assign launch    = lcd_word_i[LCD_GO_BIT] != go_ref_q;
    assign accept    = launch && lcd_word_i[LCD_ON_BIT];
    assign cnt_zero  = (cnt_q == '0);
    assign wait_done = (state_q == WAIT) && cnt_zero;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter reloads with (duration - 1) whenever the next state differs from the current one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
        case (state_q)
            IDLE:    if (accept)   state_d = SETUP;
            SETUP:   if (cnt_zero) state_d = PULSE;
            PULSE:   if (cnt_zero) state_d = HOLD;
            HOLD:    if (cnt_zero) state_d = WAIT;
            WAIT:    if (cnt_zero) state_d = (pend_q || accept) ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            case (state_d)
                SETUP:   cnt_d = CW'(T_SETUP - 1);
                PULSE:   cnt_d = CW'(T_PW - 1);
                HOLD:    cnt_d = CW'(T_HOLD - 1);
                WAIT:    cnt_d = lcd_is_long_cmd(act_rs_q, act_rw_q, act_data_q) ?
                                 CW'(T_CLR - 1) : CW'(T_EXEC - 1);
                default: cnt_d = '0;
            endcase
        end
    end

    always_comb begin
        lcd_en_o      = (state_q == PULSE);
        lcd_data_oe_o = (state_q != IDLE) && !act_rw_q;
        busy_o        = (state_q != IDLE) || pend_q;
    end

    // A freshly freed slot at the end of WAIT still counts as occupied for a same-cycle launch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            go_ref_q    <= 1'b0;
            on_q        <= 1'b0;
            act_rs_q    <= 1'b0;
            act_rw_q    <= 1'b0;
            act_data_q  <= 8'h00;
            pend_q      <= 1'b0;
            pend_rs_q   <= 1'b0;
            pend_rw_q   <= 1'b0;
            pend_data_q <= 8'h00;
            overrun_q   <= 1'b0;
        end else begin
            go_ref_q <= lcd_word_i[LCD_GO_BIT];
            on_q     <= lcd_word_i[LCD_ON_BIT];
            if (wait_done && pend_q) begin
                act_rs_q   <= pend_rs_q;
                act_rw_q   <= pend_rw_q;
                act_data_q <= pend_data_q;
                pend_q     <= 1'b0;
                if (accept) overrun_q <= 1'b1;
            end else if (accept && (state_q == IDLE || wait_done)) begin
                act_rs_q   <= word_rs;
                act_rw_q   <= word_rw;
                act_data_q <= word_data;
            end else if (accept) begin
                if (pend_q) begin
                    overrun_q <= 1'b1;
                end else begin
                    pend_q      <= 1'b1;
                    pend_rs_q   <= word_rs;
                    pend_rw_q   <= word_rw;
                    pend_data_q <= word_data;
                end
            end
        end
    end

    assign lcd_on_o   = on_q;
    assign lcd_rs_o   = act_rs_q;
    assign lcd_rw_o   = act_rw_q;
    assign lcd_data_o = act_data_q;
    assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// tb/tb_lcd_bus_sequencer.sv - self-checking bench for lcd_bus_sequencer
module tb_lcd_bus_sequencer;

    localparam int TS = 2;
    localparam int TP = 3;
    localparam int TH = 2;
    localparam int TE = 10;
    localparam int TC = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] word = 32'h0;
    logic        go = 1'b0;

    logic        lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_oe, busy, overrun;
    logic [7:0]  lcd_data;

    lcd_bus_sequencer #(
        .T_SETUP(TS), .T_PW(TP), .T_HOLD(TH), .T_EXEC(TE), .T_CLR(TC)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .lcd_word_i    (word),
        .lcd_on_o      (lcd_on),
        .lcd_en_o      (lcd_en),
        .lcd_rs_o      (lcd_rs),
        .lcd_rw_o      (lcd_rw),
        .lcd_data_o    (lcd_data),
        .lcd_data_oe_o (lcd_oe),
        .busy_o        (busy),
        .overrun_o     (overrun)
    );

    always #5 clk = ~clk;

    // Transaction-level model: k is the 1-based cycle index inside the running transaction.
    typedef struct {
        int         k;
        logic [9:0] cur;
        logic       pv;
        logic [9:0] pw;
        logic       ovr;
        logic       goref;
        logic       on;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t mreset();
        mstate_t r;
        r.k = 0; r.cur = '0; r.pv = 1'b0; r.pw = '0; r.ovr = 1'b0; r.goref = 1'b0; r.on = 1'b0;
        return r;
    endfunction

    function automatic int dur_of(input logic [9:0] f);
        logic long_cmd;
        long_cmd = !f[9] && !f[8] && (f[7:0] >= 8'd1) && (f[7:0] <= 8'd3);
        return TS + TP + TH + (long_cmd ? TC : TE);
    endfunction

    function automatic mstate_t mstep(input mstate_t s, input logic [31:0] w);
        mstate_t n;
        logic    acc;
        n       = s;
        acc     = (w[30] != s.goref) && w[31];
        n.goref = w[30];
        n.on    = w[31];
        if (s.k > 0) begin
            if (s.k == dur_of(s.cur)) begin
                if (s.pv) begin
                    n.cur = s.pw; n.pv = 1'b0; n.k = 1;
                    if (acc) n.ovr = 1'b1;
                end else if (acc) begin
                    n.cur = w[9:0]; n.k = 1;
                end else begin
                    n.k = 0;
                end
            end else begin
                n.k = s.k + 1;
                if (acc) begin
                    if (s.pv) n.ovr = 1'b1;
                    else begin n.pv = 1'b1; n.pw = w[9:0]; end
                end
            end
        end else if (acc) begin
            n.cur = w[9:0]; n.k = 1;
        end
        return n;
    endfunction

    function automatic logic [14:0] mexp(input mstate_t s);
        logic en, oe, bz;
        en = (s.k > TS) && (s.k <= TS + TP);
        oe = (s.k > 0) && !s.cur[8];
        bz = (s.k > 0) || s.pv;
        return {s.on, en, s.cur[9], s.cur[8], s.cur[7:0], oe, bz, s.ovr};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= mreset();
        else        m <= mstep(m, word);
    end

    logic [14:0] dut_vec;
    assign dut_vec = {lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data, lcd_oe, busy, overrun};

    // Per-cycle history of the pins, indexed by negedge count.
    int   cyc = 0;
    logic busy_h [0:1023];
    logic en_h   [0:1023];
    logic oe_h   [0:1023];
    logic rs_h   [0:1023];
    logic rw_h   [0:1023];
    logic [7:0] data_h [0:1023];

    always @(negedge clk) begin
        busy_h[cyc] <= busy;
        en_h[cyc]   <= lcd_en;
        oe_h[cyc]   <= lcd_oe;
        rs_h[cyc]   <= lcd_rs;
        rw_h[cyc]   <= lcd_rw;
        data_h[cyc] <= lcd_data;
        cyc         <= cyc + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flip(input logic [31:0] base);
        @(posedge clk);
        #2;
        go   = ~go;
        word = base;
        word[30] = go;
    endtask

    task automatic win(input int s, input int len, output int b, output int ef, output int ec,
                       output int rises, output int np, output int p0, output int p1, output int e2);
        b = 0; ef = -1; ec = 0; rises = 0; np = 0; p0 = -1; p1 = -1; e2 = -1;
        for (int i = 1; i <= len; i++) begin
            if (busy_h[s+i]) b++;
            if (busy_h[s+i] && !busy_h[s+i-1]) rises++;
            if (en_h[s+i]) ec++;
            if (en_h[s+i] && !en_h[s+i-1]) begin
                if (np == 0) begin ef = i; p0 = int'(data_h[s+i]); end
                else if (np == 1) begin e2 = i; p1 = int'(data_h[s+i]); end
                np++;
            end
        end
    endtask

    initial begin
        int s, b, ef, ec, rises, np, p0, p1, e2;
        bit cmp_on;
        cmp_on = 1'b1;
        fork
            forever begin
                @(negedge clk);
                if (cmp_on) check("cycle_model", int'(dut_vec), int'(mexp(m)));
            end
        join_none

        @(negedge clk);
        check("reset_outputs", int'(dut_vec), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Single data write
        flip(32'h8000_0241); s = cyc;
        repeat (25) @(posedge clk); #2;
        win(s, 22, b, ef, ec, rises, np, p0, p1, e2);
        check("t1_busy_len", b, 17);
        check("t1_en_first", ef, 3);
        check("t1_en_len", ec, 3);
        check("t1_data", int'(data_h[s+1]), 'h41);
        check("t1_rs", int'(rs_h[s+1]), 1);
        check("t1_oe", int'(oe_h[s+1]), 1);

        // Clear display uses the long wait
        flip(32'h8000_0001); s = cyc;
        repeat (52) @(posedge clk); #2;
        win(s, 50, b, ef, ec, rises, np, p0, p1, e2);
        check("t2_busy_len", b, 47);
        check("t2_en_first", ef, 3);
        check("t2_en_len", ec, 3);

        // Back-to-back through the pending slot
        flip(32'h8000_0241); s = cyc;
        repeat (4) @(posedge clk);
        flip(32'h8000_0242);
        repeat (42) @(posedge clk); #2;
        win(s, 42, b, ef, ec, rises, np, p0, p1, e2);
        check("t3_busy_len", b, 34);
        check("t3_busy_rises", rises, 1);
        check("t3_pulses", np, 2);
        check("t3_p0", p0, 'h41);
        check("t3_p1", p1, 'h42);
        check("t3_en2_start", e2, 20);
        check("t3_overrun", int'(overrun), 0);

        // Third launch is dropped
        flip(32'h8000_0241); s = cyc;
        repeat (2) @(posedge clk);
        flip(32'h8000_0242);
        repeat (2) @(posedge clk);
        flip(32'h8000_0243);
        repeat (42) @(posedge clk); #2;
        win(s, 42, b, ef, ec, rises, np, p0, p1, e2);
        check("t4_busy_len", b, 34);
        check("t4_pulses", np, 2);
        check("t4_p0", p0, 'h41);
        check("t4_p1", p1, 'h42);
        check("t4_overrun", int'(overrun), 1);

        // GO flip with ON=0 is ignored
        flip(32'h0000_0041); s = cyc;
        repeat (22) @(posedge clk); #2;
        win(s, 20, b, ef, ec, rises, np, p0, p1, e2);
        check("t5_busy_len", b, 0);
        check("t5_en_len", ec, 0);
        check("t5_on", int'(lcd_on), 0);

        // Read cycle: same timing, bus not driven
        flip(32'h8000_0141); s = cyc;
        repeat (22) @(posedge clk); #2;
        win(s, 20, b, ef, ec, rises, np, p0, p1, e2);
        check("t6_busy_len", b, 17);
        check("t6_en_len", ec, 3);
        check("t6_oe", int'(oe_h[s+1]), 0);
        check("t6_rw", int'(rw_h[s+1]), 1);
        check("t6_overrun_sticky", int'(overrun), 1);

        // Reset while EN is high
        flip(32'h8000_0241);
        repeat (3) @(posedge clk); #2;
        check("t7_en_before_reset", int'(lcd_en), 1);
        rst_n = 1'b0;
        #1;
        check("t7_en_async", int'(lcd_en), 0);
        check("t7_outputs_reset", int'(dut_vec), 0);
        repeat (2) @(posedge clk); #2;
        rst_n = 1'b1;
        s = cyc;
        repeat (22) @(posedge clk); #2;
        win(s, 20, b, ef, ec, rises, np, p0, p1, e2);
        check("t7_no_relaunch_busy", b, 0);
        check("t7_no_relaunch_en", ec, 0);

        cmp_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
